cmd_link: RTL

// Host-side link partner of the digital core. Assembles pairs of received UART bytes into the 16-bit
// cmd/cmd_rdy the core consumes, and honours clr_cmd_rdy. It also serialises the core's 8-bit resp
// (send_resp) onto the TX line and returns resp_sent when the frame completes.

---
 rtl/cmd_link.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cmd_link.sv
// cmd_link: host-side link partner of the digital core.
//   RX path: pairs UART bytes into a 16-bit command {first, second} with an
//            inter-byte timeout. The finished command is held until the
//            consumer acknowledges it.
//   TX path: serialises an 8-bit response as 8N1, LSB first. It pulses
//            o_resp_sent in the last cycle of the stop bit.
// The two paths are fully independent.
module cmd_link #(
    parameter int BAUD_DIV = 2604,     // clk cycles per UART bit, >= 2
    parameter int TIMEOUT  = 1000000   // clk cycles allowed between cmd bytes, >= 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_rdy,
    output logic        o_clr_rx_rdy,
    output logic [15:0] o_cmd,
    output logic        o_cmd_rdy,
    input  logic        i_clr_cmd_rdy,
    output logic        o_cmd_err,
    input  logic [7:0]  i_resp,
    input  logic        i_send_resp,
    output logic        o_resp_sent,
    output logic        o_tx,
    output logic        o_tx_busy
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int BW = $clog2(BAUD_DIV);

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0]    STOP_IDX  = 4'd9;

    // RX FSM encoding
    localparam logic [1:0] WAIT_H = 2'd0;
    localparam logic [1:0] WAIT_L = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    // TX FSM encoding
    localparam logic [0:0] TX_IDLE  = 1'b0;
    localparam logic [0:0] TX_SHIFT = 1'b1;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [1:0]    r_rx_st;
    logic [7:0]    r_hi_byte;
    logic [15:0]   r_cmd;
    logic          r_cmd_rdy;
    logic          r_cmd_err;
    logic [TW-1:0] r_tmo_cnt;
    logic          w_rx_take;

    // Bytes are consumed only while assembling a command. In HOLD the byte
    // stays pending at the receiver until the command is acknowledged.
    assign w_rx_take    = i_rx_rdy && ((r_rx_st == WAIT_H) || (r_rx_st == WAIT_L));
    assign o_clr_rx_rdy = !i_rst && w_rx_take;

    // Command assembly, inter-byte timeout and hold-until-acknowledged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_st   <= WAIT_H;
            r_hi_byte <= '0;
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
            r_cmd_err <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_cmd_err <= 1'b0;
            case (r_rx_st)
                WAIT_H: begin
                    if (i_rx_rdy) begin
                        r_hi_byte <= i_rx_data;
                        r_tmo_cnt <= '0;
                        r_rx_st   <= WAIT_L;
                    end
                end
                WAIT_L: begin
                    // A byte arriving in the final allowed cycle still wins.
                    if (i_rx_rdy) begin
                        r_cmd     <= {r_hi_byte, i_rx_data};
                        r_cmd_rdy <= 1'b1;
                        r_rx_st   <= HOLD;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_cmd_err <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_rx_st   <= WAIT_H;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                HOLD: begin
                    if (i_clr_cmd_rdy) begin
                        r_cmd_rdy <= 1'b0;
                        r_rx_st   <= WAIT_H;
                    end
                end
                default: r_rx_st <= WAIT_H;
            endcase
        end
    end

    assign o_cmd     = r_cmd;
    assign o_cmd_rdy = r_cmd_rdy;
    assign o_cmd_err = r_cmd_err;

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [0:0]    r_tx_st;
    logic [9:0]    r_shreg;
    logic [BW-1:0] r_baud_cnt;
    logic [3:0]    r_bit_cnt;
    logic          r_tx_busy;
    logic          w_bit_end;

    assign w_bit_end = (r_tx_st == TX_SHIFT) && (r_baud_cnt == BAUD_LAST);

    // Frame shifter. The line is always shreg[0]. Ones are shifted in, so
    // the line rests high once the stop bit has gone out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_st    <= TX_IDLE;
            r_shreg    <= '1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx_busy  <= 1'b0;
        end else begin
            case (r_tx_st)
                TX_IDLE: begin
                    if (i_send_resp) begin
                        r_shreg    <= {1'b1, i_resp, 1'b0};
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_tx_busy  <= 1'b1;
                        r_tx_st    <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_shreg    <= {1'b1, r_shreg[9:1]};
                        if (r_bit_cnt == STOP_IDX) begin
                            r_bit_cnt <= '0;
                            r_tx_busy <= 1'b0;
                            r_tx_st   <= TX_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BW'(1);
                    end
                end
                default: r_tx_st <= TX_IDLE;
            endcase
        end
    end

    // resp_sent marks the last cycle of the stop bit, which is still a
    // busy cycle. A send_resp seen in that cycle is therefore ignored.
    assign o_resp_sent = !i_rst && w_bit_end && (r_bit_cnt == STOP_IDX);
    assign o_tx        = r_shreg[0];
    assign o_tx_busy   = r_tx_busy;

endmodule
